cve2_mac_sequencer: RTL and testbench

- Parametrised multi-channel MAC sequencer for the cve2 EX stage.
- Accepts MAC-family requests, drives the shared EX multiplier with a variable-latency handshake, and accumulates into one of NumAcc internal wide accumulators.
- Accumulation can optionally saturate; the 32-bit result is returned through a valid/ready handshake.
- Successor to the fixed two-cycle MUL-then-ADD controller: adds multiple accumulators, modes, variable multiplier latency, flush and back-pressure.

---
 rtl/cve2_pkg.sv | 18 +
 rtl/cve2_mac_sat.sv | 59 +++++
 rtl/cve2_mac_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_cve2_mac_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cve2_pkg.sv
// Shared cve2 EX-stage types: MAC request modes and MAC sequencer FSM states.
package cve2_pkg;

   typedef enum logic [1:0] {
      MAC_OP_MAC   = 2'd0,
      MAC_OP_MSU   = 2'd1,
      MAC_OP_MULZ  = 2'd2,
      MAC_OP_RDACC = 2'd3
   } mac_mode_e;

   typedef enum logic [1:0] {
      MAC_IDLE = 2'd0,
      MAC_MUL  = 2'd1,
      MAC_ACC  = 2'd2,
      MAC_RESP = 2'd3
   } mac_seq_state_e;

endpackage

// File: rtl/cve2_mac_sat.sv
// Combinational accumulate step: extend product, add/sub/replace, overflow detect,
// optional signed saturation, then clamp the new accumulator to a 32-bit result.
module cve2_mac_sat
   import cve2_pkg::*;
#(
   parameter int unsigned AccWidth = 64,
   parameter bit          Saturate = 1'b1
) (
   input  mac_mode_e             mode_i,
   input  logic                  signed_i,
   input  logic [AccWidth-1:0]   acc_i,
   input  logic [63:0]           prod_i,
   output logic [AccWidth-1:0]   acc_o,
   output logic                  acc_ovf_o,
   output logic [31:0]           res_o,
   output logic                  res_ovf_o
);

   logic [64:0]           prod_x;
   logic [AccWidth-1:0]   prod_ext;
   logic [AccWidth:0]     acc_w;
   logic [AccWidth:0]     prod_w;
   logic [AccWidth:0]     sum_w;
   logic [AccWidth-1:31]  acc_hi;
   logic                  unused_prod_hi;

   // The product is already full width, so extension only decides bit 64;
   // narrower accumulators simply keep the low AccWidth bits.
   assign prod_x         = {signed_i & prod_i[63], prod_i};
   assign prod_ext       = prod_x[AccWidth-1:0];
   assign unused_prod_hi = ^prod_x[64:AccWidth];

   always_comb begin
      acc_w  = {acc_i[AccWidth-1], acc_i};
      prod_w = {prod_ext[AccWidth-1], prod_ext};
      case (mode_i)
         MAC_OP_MAC:  sum_w = acc_w + prod_w;
         MAC_OP_MSU:  sum_w = acc_w - prod_w;
         MAC_OP_MULZ: sum_w = prod_w;
         default:     sum_w = acc_w;
      endcase

      acc_ovf_o = sum_w[AccWidth] ^ sum_w[AccWidth-1];
      if (Saturate && acc_ovf_o) begin
         acc_o = sum_w[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}} : {1'b0, {(AccWidth-1){1'b1}}};
      end else begin
         acc_o = sum_w[AccWidth-1:0];
      end

      acc_hi    = acc_o[AccWidth-1:31];
      res_o     = acc_o[31:0];
      res_ovf_o = 1'b0;
      if (Saturate && !((&acc_hi) || !(|acc_hi))) begin
         res_ovf_o = 1'b1;
         res_o     = acc_o[AccWidth-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end

endmodule

// File: rtl/cve2_mac_sequencer.sv
// Multi-channel MAC sequencer: IDLE -> MUL (waits on mul_valid_i) -> ACC -> RESP.
// Result 3 cycles after accept (RDACC: 1); RESP holds until result_ready_i, no accept meanwhile.
module cve2_mac_sequencer
   import cve2_pkg::*;
#(
   parameter int unsigned  NumAcc   = 4,
   parameter int unsigned  AccWidth = 64,
   parameter bit           Saturate = 1'b1,
   localparam int unsigned SelW     = (NumAcc > 1) ? $clog2(NumAcc) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mac_valid_i,
   output logic              mac_ready_o,
   input  mac_mode_e         mac_mode_i,
   input  logic [SelW-1:0]   mac_acc_sel_i,
   input  logic [31:0]       op_a_i,
   input  logic [31:0]       op_b_i,
   input  logic              signed_i,
   output logic              mul_req_o,
   output logic [31:0]       mul_op_a_o,
   output logic [31:0]       mul_op_b_o,
   output logic              mul_signed_o,
   input  logic              mul_valid_i,
   input  logic [63:0]       mul_result_i,
   input  logic              flush_i,
   output logic              result_valid_o,
   input  logic              result_ready_i,
   output logic [31:0]       result_o,
   output logic              ovf_o,
   output logic              busy_o
);

   localparam int unsigned AccDepth = 1 << SelW;

   mac_seq_state_e       state_q, state_d;
   mac_mode_e            mode_q, mode_d;
   logic [SelW-1:0]      sel_q, sel_d;
   logic [31:0]          op_a_q, op_a_d, op_b_q, op_b_d;
   logic                 signed_q, signed_d;
   logic [63:0]          prod_q, prod_d;
   logic [31:0]          res_q, res_d;
   logic                 ovf_q, ovf_d;
   logic [AccWidth-1:0]  acc_q [AccDepth];
   logic [AccWidth-1:0]  acc_d [AccDepth];

   mac_mode_e            sat_mode;
   logic [SelW-1:0]      sat_sel;
   logic [AccWidth-1:0]  acc_rd, sat_acc;
   logic                 sat_acc_ovf, sat_res_ovf, sel_ok, acc_we;
   logic [31:0]          sat_res;

   // In IDLE the datapath looks at the incoming request so RDACC can respond next cycle.
   always_comb begin
      sat_mode = (state_q == MAC_IDLE) ? mac_mode_i : mode_q;
      sat_sel  = (state_q == MAC_IDLE) ? mac_acc_sel_i : sel_q;
      acc_rd   = acc_q[sat_sel];
   end

   // Selectors beyond NumAcc turn the request into a no-op returning 0.
   always_comb begin
      sel_ok = 1'b0;
      for (int i = 0; i < NumAcc; i++) begin
         if (sat_sel == SelW'(i)) sel_ok = 1'b1;
      end
   end

   cve2_mac_sat #(
      .AccWidth (AccWidth),
      .Saturate (Saturate)
   ) u_sat (
      .mode_i    (sat_mode),
      .signed_i  (signed_q),
      .acc_i     (acc_rd),
      .prod_i    (prod_q),
      .acc_o     (sat_acc),
      .acc_ovf_o (sat_acc_ovf),
      .res_o     (sat_res),
      .res_ovf_o (sat_res_ovf)
   );

   always_comb begin
      state_d        = state_q;
      mode_d         = mode_q;
      sel_d          = sel_q;
      op_a_d         = op_a_q;
      op_b_d         = op_b_q;
      signed_d       = signed_q;
      prod_d         = prod_q;
      res_d          = res_q;
      ovf_d          = ovf_q;
      acc_d          = acc_q;
      acc_we         = 1'b0;
      mac_ready_o    = 1'b0;
      mul_req_o      = 1'b0;
      result_valid_o = 1'b0;
      busy_o         = 1'b1;

      case (state_q)
         MAC_IDLE: begin
            busy_o      = 1'b0;
            mac_ready_o = ~flush_i;
            if (mac_valid_i && !flush_i) begin
               mode_d   = mac_mode_i;
               sel_d    = mac_acc_sel_i;
               op_a_d   = op_a_i;
               op_b_d   = op_b_i;
               signed_d = signed_i;
               if (mac_mode_i == MAC_OP_RDACC) begin
                  res_d   = sel_ok ? sat_res : 32'h0;
                  ovf_d   = sel_ok & sat_res_ovf;
                  state_d = MAC_RESP;
               end else begin
                  state_d = MAC_MUL;
               end
            end
         end
         MAC_MUL: begin
            mul_req_o = 1'b1;
            if (flush_i) begin
               state_d = MAC_IDLE;
            end else if (mul_valid_i) begin
               prod_d  = mul_result_i;
               state_d = MAC_ACC;
            end
         end
         MAC_ACC: begin
            if (flush_i) begin
               state_d = MAC_IDLE;
            end else begin
               acc_we  = sel_ok;
               res_d   = sel_ok ? sat_res : 32'h0;
               ovf_d   = sel_ok & (sat_acc_ovf | sat_res_ovf);
               state_d = MAC_RESP;
            end
         end
         MAC_RESP: begin
            result_valid_o = 1'b1;
            if (flush_i || result_ready_i) state_d = MAC_IDLE;
         end
         default: state_d = MAC_IDLE;
      endcase

      for (int i = 0; i < NumAcc; i++) begin
         if (acc_we && (sel_q == SelW'(i))) acc_d[i] = sat_acc;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= MAC_IDLE;
         mode_q   <= MAC_OP_MAC;
         sel_q    <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         signed_q <= 1'b0;
         prod_q   <= '0;
         res_q    <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < AccDepth; i++) acc_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         sel_q    <= sel_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         signed_q <= signed_d;
         prod_q   <= prod_d;
         res_q    <= res_d;
         ovf_q    <= ovf_d;
         acc_q    <= acc_d;
      end
   end

   assign mul_op_a_o   = op_a_q;
   assign mul_op_b_o   = op_b_q;
   assign mul_signed_o = signed_q;
   assign result_o     = res_q;
   assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_cve2_mac_sequencer.sv
// Directed bench: two sequencers in lockstep, u_a (4 x 64-bit, saturating) and
// u_b (3 x 32-bit, wrapping), fed by one multiplier model with programmable latency.
module tb_cve2_mac_sequencer;
   import cve2_pkg::*;

   logic        clk = 1'b0;
   logic        rst, mac_valid, sgn, flush, res_rdy, mul_valid, mul_force;
   mac_mode_e   mode;
   logic [1:0]  sel;
   logic [31:0] op_a, op_b;
   int          mul_cnt, mul_lat, last_req;
   int          n_cmp = 0;
   int          n_err = 0;

   logic        rdy_a, req_a, msg_a, rv_a, ovf_a, busy_a;
   logic [31:0] opa_a, opb_a, res_a;
   logic [63:0] mres_a;
   logic        rdy_b, req_b, msg_b, rv_b, ovf_b, busy_b;
   logic [31:0] opa_b, opb_b, res_b;
   logic [63:0] mres_b;

   always #5 clk = ~clk;

   // Multiplier model: product of the registered operands, valid mul_lat cycles after req rises.
   assign mres_a = {{32{opa_a[31] & msg_a}}, opa_a} * {{32{opb_a[31] & msg_a}}, opb_a};
   assign mres_b = {{32{opa_b[31] & msg_b}}, opa_b} * {{32{opb_b[31] & msg_b}}, opb_b};
   assign mul_valid = (req_a && (mul_cnt == mul_lat)) || mul_force;
   always @(posedge clk) mul_cnt <= req_a ? mul_cnt + 1 : 0;

   cve2_mac_sequencer #(.NumAcc(4), .AccWidth(64), .Saturate(1'b1)) u_a (
      .clk_i(clk), .rst_i(rst), .mac_valid_i(mac_valid), .mac_ready_o(rdy_a),
      .mac_mode_i(mode), .mac_acc_sel_i(sel), .op_a_i(op_a), .op_b_i(op_b), .signed_i(sgn),
      .mul_req_o(req_a), .mul_op_a_o(opa_a), .mul_op_b_o(opb_a), .mul_signed_o(msg_a),
      .mul_valid_i(mul_valid), .mul_result_i(mres_a), .flush_i(flush),
      .result_valid_o(rv_a), .result_ready_i(res_rdy), .result_o(res_a), .ovf_o(ovf_a),
      .busy_o(busy_a));

   cve2_mac_sequencer #(.NumAcc(3), .AccWidth(32), .Saturate(1'b0)) u_b (
      .clk_i(clk), .rst_i(rst), .mac_valid_i(mac_valid), .mac_ready_o(rdy_b),
      .mac_mode_i(mode), .mac_acc_sel_i(sel), .op_a_i(op_a), .op_b_i(op_b), .signed_i(sgn),
      .mul_req_o(req_b), .mul_op_a_o(opa_b), .mul_op_b_o(opb_b), .mul_signed_o(msg_b),
      .mul_valid_i(mul_valid), .mul_result_i(mres_b), .flush_i(flush),
      .result_valid_o(rv_b), .result_ready_i(res_rdy), .result_o(res_b), .ovf_o(ovf_b),
      .busy_o(busy_b));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Present one request and hold it across the accept edge.
   task automatic send(input mac_mode_e m, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic sg);
      mac_valid = 1'b1; mode = m; sel = s; op_a = a; op_b = b; sgn = sg;
      #1;
      chk("send_rdy", rdy_a, 1);
      tick();
      mac_valid = 1'b0;
   endtask

   // Cycles from accept to result_valid (1 = cycle after accept), bounded.
   task automatic wait_rv(input string tag, output int lat);
      lat = 1;
      last_req = 0;
      while (!rv_a && lat < 40) begin
         if (req_a) last_req++;
         tick();
         lat++;
      end
      chk({tag, "_vld"}, rv_a, 1);
   endtask

   task automatic resp(input string tag, input int elat, input logic [31:0] ea, input logic eoa,
                       input logic [31:0] eb, input logic eob);
      int lat;
      wait_rv(tag, lat);
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_res_a"}, res_a, ea);
      chk({tag, "_ovf_a"}, ovf_a, eoa);
      chk({tag, "_res_b"}, res_b, eb);
      chk({tag, "_ovf_b"}, ovf_b, eob);
      res_rdy = 1'b1;
      tick();
      res_rdy = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lat;
      rst = 1'b1; mac_valid = 1'b0; mode = MAC_OP_MAC; sel = 2'd0; op_a = '0; op_b = '0;
      sgn = 1'b0; flush = 1'b0; res_rdy = 1'b0; mul_force = 1'b0; mul_lat = 0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_rdy_a", rdy_a, 1);
      chk("rst_rdy_b", rdy_b, 1);
      chk("rst_busy", busy_a, 0);
      chk("rst_rv", rv_a, 0);
      chk("rst_req", req_a, 0);
      chk("rst_res", res_a, 0);
      chk("rst_ovf", ovf_a, 0);
      chk("rst_opa", opa_a, 0);

      // Basic signed MAC with a combinational multiplier, then read it back.
      send(MAC_OP_MAC, 2'd0, 32'd3, 32'd4, 1'b1);
      resp("mac0", 3, 32'd12, 1'b0, 32'd12, 1'b0);
      send(MAC_OP_RDACC, 2'd0, 32'd0, 32'd0, 1'b0);
      resp("rd0", 1, 32'd12, 1'b0, 32'd12, 1'b0);

      // MSU with a 3-cycle-late multiplier: 0 - 2*5.
      mul_lat = 3;
      send(MAC_OP_MSU, 2'd1, 32'd2, 32'd5, 1'b1);
      resp("msu1", 6, 32'hFFFF_FFF6, 1'b0, 32'hFFFF_FFF6, 1'b0);
      chk("msu1_req_cycles", last_req, 4);
      mul_lat = 0;

      // Saturation: P = 0x3FFFFFFF00000001; acc2 = P, 2P, sat(3P).
      send(MAC_OP_MULZ, 2'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      resp("sat1", 3, 32'h7FFF_FFFF, 1'b1, 32'd1, 1'b0);
      send(MAC_OP_MAC, 2'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      resp("sat2", 3, 32'h7FFF_FFFF, 1'b1, 32'd2, 1'b0);
      send(MAC_OP_MAC, 2'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      resp("sat3", 3, 32'h7FFF_FFFF, 1'b1, 32'd3, 1'b0);
      send(MAC_OP_RDACC, 2'd2, 32'd0, 32'd0, 1'b0);
      resp("sat_rd", 1, 32'h7FFF_FFFF, 1'b1, 32'd3, 1'b0);

      // Flush during MUL, then a stray late multiplier valid while idle.
      mul_lat = 10;
      send(MAC_OP_MAC, 2'd3, 32'd5, 32'd7, 1'b1);
      chk("fl_req", req_a, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_req_drop", req_a, 0);
      chk("fl_busy", busy_a, 0);
      mul_force = 1'b1;
      tick();
      mul_force = 1'b0;
      chk("fl_late_busy", busy_a, 0);
      chk("fl_late_rv", rv_a, 0);
      mul_lat = 0;
      send(MAC_OP_RDACC, 2'd3, 32'd0, 32'd0, 1'b0);
      resp("fl_rd", 1, 32'd0, 1'b0, 32'd0, 1'b0);

      // Flush in IDLE blocks acceptance.
      mac_valid = 1'b1; mode = MAC_OP_MAC; sel = 2'd0;
      flush = 1'b1;
      #1;
      chk("idle_fl_rdy", rdy_a, 0);
      tick();
      mac_valid = 1'b0; flush = 1'b0;
      chk("idle_fl_busy", busy_a, 0);

      // Back-pressure: result held stable for 5 cycles.
      send(MAC_OP_MAC, 2'd0, 32'd1, 32'd1, 1'b1);
      wait_rv("hold", lat);
      for (int i = 0; i < 5; i++) begin
         chk("hold_res", res_a, 32'd13);
         chk("hold_busy", busy_a, 1);
         chk("hold_rdy", rdy_a, 0);
         tick();
      end
      chk("hold_vld", rv_a, 1);
      res_rdy = 1'b1;
      tick();
      res_rdy = 1'b0;
      chk("b2b_rdy", rdy_a, 1);

      // Selector 3 is a real channel for u_a but out of range for u_b.
      send(MAC_OP_MAC, 2'd3, 32'd2, 32'd3, 1'b1);
      resp("sel3", 3, 32'd6, 1'b0, 32'd0, 1'b0);
      send(MAC_OP_RDACC, 2'd3, 32'd0, 32'd0, 1'b0);
      resp("sel3_rd", 1, 32'd6, 1'b0, 32'd0, 1'b0);

      // Flush in RESP drops the result but keeps the accumulator update: -10 + 20.
      send(MAC_OP_MAC, 2'd1, 32'd1, 32'd20, 1'b1);
      wait_rv("flr", lat);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flr_rv", rv_a, 0);
      chk("flr_busy", busy_a, 0);
      send(MAC_OP_RDACC, 2'd1, 32'd0, 32'd0, 1'b0);
      resp("flr_rd", 1, 32'd10, 1'b0, 32'd10, 1'b0);

      // Fresh reset, then unsigned MAC: 32-bit wrap on u_b, 32-bit clamp on u_a.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      send(MAC_OP_MAC, 2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
      resp("umac", 3, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFE, 1'b0);

      // Reset while in ACC discards the write.
      send(MAC_OP_MAC, 2'd1, 32'd5, 32'd5, 1'b1);
      tick();
      chk("racc_busy", busy_b, 1);
      chk("racc_req", req_b, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("racc_idle", busy_b, 0);
      chk("racc_rv", rv_b, 0);
      send(MAC_OP_RDACC, 2'd1, 32'd0, 32'd0, 1'b0);
      resp("racc_rd", 1, 32'd0, 1'b0, 32'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
